// File: rtl/array_allocator_if.sv
// Handshake and statistics bundle between the array allocator and its alloc/free requesters.
interface array_allocator_if #(parameter int W = 12);
  logic         allocReq;
  logic         allocAck;
  logic [W-1:0] allocArray;
  logic         allocFail;
  logic         freeReq;
  logic [W-1:0] freeArray;
  logic         freeAck;
  logic         freeError;
  logic [W-1:0] inUse;
  logic [W-1:0] allocs;
  logic         full;

  modport master (
    output allocReq, freeReq, freeArray,
    input  allocAck, allocArray, allocFail, freeAck, freeError, inUse, allocs, full
  );

  modport slave (
    input  allocReq, freeReq, freeArray,
    output allocAck, allocArray, allocFail, freeAck, freeError, inUse, allocs, full
  );
endinterface

// File: rtl/array_allocator.sv
// Heap array-handle allocator: LIFO reuse of freed handles, bump allocation otherwise,
// alloc/free arbitration with toggling priority, and in-use / high-water statistics.
module array_allocator #(
  parameter int MemoryElementWidth = 12,
  parameter int NArrays            = 20
) (
  input  logic             clock,
  input  logic             reset,
  array_allocator_if.slave io
);
  localparam int W  = MemoryElementWidth;
  localparam int IW = $clog2(NArrays);
  localparam int SD = NArrays - 1;
  localparam logic [W-1:0] N_W = W'(NArrays);

  typedef enum logic [1:0] {IDLE, ACK, WAIT} state_e;

  state_e             state_q, state_d;
  logic               prio_alloc_q, prio_alloc_d;
  logic               served_alloc_q, served_alloc_d;
  logic               alloc_ack_q, alloc_ack_d;
  logic               free_ack_q, free_ack_d;
  logic [W-1:0]       alloc_array_q, alloc_array_d;
  logic               alloc_fail_q, alloc_fail_d;
  logic               free_error_q, free_error_d;
  logic [W-1:0]       next_q, next_d;
  logic [W-1:0]       top_q, top_d;
  logic [NArrays-1:0] used_q, used_d;
  logic [W-1:0]       in_use_q, in_use_d;
  logic [W-1:0]       allocs_q, allocs_d;
  logic [W-1:0]       stack_q [SD];
  logic [W-1:0]       stack_d [SD];

  logic               take_alloc;
  logic               free_bad;
  logic               grant_ok;
  logic [W-1:0]       grant_h;
  logic [IW-1:0]      pop_idx;

  assign take_alloc = io.allocReq && (!io.freeReq || prio_alloc_q);
  assign pop_idx    = IW'(top_q - W'(1));
  // Null, never-issued and already-free handles are all rejected without touching state.
  assign free_bad   = (io.freeArray == '0) || (io.freeArray >= next_q) ||
                      !used_q[IW'(io.freeArray)];

  always_comb begin
    state_d        = state_q;
    prio_alloc_d   = prio_alloc_q;
    served_alloc_d = served_alloc_q;
    alloc_ack_d    = alloc_ack_q;
    free_ack_d     = free_ack_q;
    alloc_array_d  = alloc_array_q;
    alloc_fail_d   = alloc_fail_q;
    free_error_d   = free_error_q;
    next_d         = next_q;
    top_d          = top_q;
    used_d         = used_q;
    in_use_d       = in_use_q;
    allocs_d       = allocs_q;
    stack_d        = stack_q;
    grant_ok       = 1'b0;
    grant_h        = '0;
    case (state_q)
      IDLE: begin
        if (take_alloc) begin
          served_alloc_d = 1'b1;
          prio_alloc_d   = 1'b0;
          alloc_ack_d    = 1'b1;
          state_d        = ACK;
          if (top_q != '0) begin
            grant_ok = 1'b1;
            grant_h  = stack_q[pop_idx];
            top_d    = top_q - W'(1);
          end else if (next_q < N_W) begin
            grant_ok = 1'b1;
            grant_h  = next_q;
            next_d   = next_q + W'(1);
          end
          alloc_fail_d  = !grant_ok;
          alloc_array_d = grant_ok ? grant_h : '0;
          if (grant_ok) begin
            used_d[IW'(grant_h)] = 1'b1;
            in_use_d = in_use_q + W'(1);
            if (in_use_d > allocs_q) allocs_d = in_use_d;
          end
        end else if (io.freeReq) begin
          served_alloc_d = 1'b0;
          prio_alloc_d   = 1'b1;
          free_ack_d     = 1'b1;
          free_error_d   = free_bad;
          state_d        = ACK;
          if (!free_bad) begin
            used_d[IW'(io.freeArray)] = 1'b0;
            stack_d[IW'(top_q)]       = io.freeArray;
            top_d    = top_q + W'(1);
            in_use_d = in_use_q - W'(1);
          end
        end
      end
      ACK: state_d = WAIT;
      WAIT: begin
        // Hold ack and results until the served requester lets go.
        if (!(served_alloc_q ? io.allocReq : io.freeReq)) begin
          state_d       = IDLE;
          alloc_ack_d   = 1'b0;
          free_ack_d    = 1'b0;
          alloc_array_d = '0;
          alloc_fail_d  = 1'b0;
          free_error_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      prio_alloc_q   <= 1'b1;
      served_alloc_q <= 1'b0;
      alloc_ack_q    <= 1'b0;
      free_ack_q     <= 1'b0;
      alloc_array_q  <= '0;
      alloc_fail_q   <= 1'b0;
      free_error_q   <= 1'b0;
      next_q         <= W'(1);
      top_q          <= '0;
      used_q         <= '0;
      in_use_q       <= '0;
      allocs_q       <= '0;
    end else begin
      state_q        <= state_d;
      prio_alloc_q   <= prio_alloc_d;
      served_alloc_q <= served_alloc_d;
      alloc_ack_q    <= alloc_ack_d;
      free_ack_q     <= free_ack_d;
      alloc_array_q  <= alloc_array_d;
      alloc_fail_q   <= alloc_fail_d;
      free_error_q   <= free_error_d;
      next_q         <= next_d;
      top_q          <= top_d;
      used_q         <= used_d;
      in_use_q       <= in_use_d;
      allocs_q       <= allocs_d;
    end
  end

  // Stack contents are only meaningful below top, so they need no reset.
  always_ff @(posedge clock) begin
    stack_q <= stack_d;
  end

  assign io.allocAck   = alloc_ack_q;
  assign io.allocArray = alloc_array_q;
  assign io.allocFail  = alloc_fail_q;
  assign io.freeAck    = free_ack_q;
  assign io.freeError  = free_error_q;
  assign io.inUse      = in_use_q;
  assign io.allocs     = allocs_q;
  assign io.full       = (top_q == '0) && (next_q == N_W);
endmodule

// File: tb/tb_array_allocator.sv
// Directed bench for array_allocator: queue-based pool model checked every cycle plus literal expectations.
module tb_array_allocator;
  localparam int W = 12;
  localparam int N = 20;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  array_allocator_if #(.W(W)) io();

  array_allocator #(.MemoryElementWidth(W), .NArrays(N)) dut (
    .clock(clock),
    .reset(reset),
    .io(io.slave)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Pool model: freed handles as a LIFO queue, bump pointer, set of live handles.
  int fq[$];
  int nxt, inuse, hw;
  bit used[N];
  int exp_aa;
  bit exp_af, exp_fe;
  bit pa, pf, rst_edge, started;
  int order[$];

  always @(posedge clock) rst_edge <= reset;

  always @(negedge clock) begin
    if (rst_edge) begin
      fq.delete();
      nxt = 1; inuse = 0; hw = 0;
      for (int i = 0; i < N; i++) used[i] = 1'b0;
      pa = 1'b0; pf = 1'b0; started = 1'b1;
      chk("rst_allocAck", io.allocAck, 0);
      chk("rst_allocArray", io.allocArray, 0);
      chk("rst_allocFail", io.allocFail, 0);
      chk("rst_freeAck", io.freeAck, 0);
      chk("rst_freeError", io.freeError, 0);
      chk("rst_inUse", io.inUse, 0);
      chk("rst_allocs", io.allocs, 0);
      chk("rst_full", io.full, 0);
    end else if (started) begin
      if (io.allocAck && !pa) begin
        order.push_back(1);
        exp_af = 1'b0;
        if (fq.size() > 0) exp_aa = fq.pop_back();
        else if (nxt < N) begin exp_aa = nxt; nxt++; end
        else begin exp_aa = 0; exp_af = 1'b1; end
        if (!exp_af) begin
          used[exp_aa] = 1'b1;
          inuse++;
          if (inuse > hw) hw = inuse;
        end
      end
      if (io.freeAck && !pf) begin
        int h;
        order.push_back(2);
        h = int'(io.freeArray);
        exp_fe = (h == 0) || (h >= nxt) || !used[h];
        if (!exp_fe) begin
          used[h] = 1'b0;
          fq.push_back(h);
          inuse--;
        end
      end
      if (io.allocAck) begin
        chk("mdl_allocArray", io.allocArray, exp_aa);
        chk("mdl_allocFail", io.allocFail, exp_af);
      end
      if (io.freeAck) chk("mdl_freeError", io.freeError, exp_fe);
      chk("mdl_inUse", io.inUse, inuse);
      chk("mdl_allocs", io.allocs, hw);
      chk("mdl_full", io.full, (fq.size() == 0) && (nxt == N));
      pa = io.allocAck;
      pf = io.freeAck;
    end
  end

  task automatic tick();
    @(posedge clock); #2;
  endtask

  task automatic do_reset();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic do_alloc(output int h, output int f);
    int n;
    io.allocReq = 1'b1;
    n = 0;
    while (!io.allocAck && n < 40) begin tick(); n++; end
    if (!io.allocAck) begin tests++; fails++; $display("FAIL alloc_ack_timeout: allocAck=0 required 1"); end
    h = int'(io.allocArray);
    f = int'(io.allocFail);
    io.allocReq = 1'b0;
    n = 0;
    while (io.allocAck && n < 40) begin tick(); n++; end
    if (io.allocAck) begin tests++; fails++; $display("FAIL alloc_drop_timeout: allocAck=1 required 0"); end
  endtask

  task automatic do_free(input int h, output int e);
    int n;
    io.freeArray = W'(h);
    io.freeReq = 1'b1;
    n = 0;
    while (!io.freeAck && n < 40) begin tick(); n++; end
    if (!io.freeAck) begin tests++; fails++; $display("FAIL free_ack_timeout: freeAck=0 required 1"); end
    e = int'(io.freeError);
    io.freeReq = 1'b0;
    n = 0;
    while (io.freeAck && n < 40) begin tick(); n++; end
    if (io.freeAck) begin tests++; fails++; $display("FAIL free_drop_timeout: freeAck=1 required 0"); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1);
  end

  initial begin
    int h, f, e, h2, f2;
    io.allocReq = 1'b0;
    io.freeReq = 1'b0;
    io.freeArray = '0;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;

    // Bump allocation
    for (int i = 1; i <= 3; i++) begin
      do_alloc(h, f);
      chk($sformatf("bump_h%0d", i), h, i);
      chk($sformatf("bump_f%0d", i), f, 0);
    end
    chk("bump_inUse", io.inUse, 3);
    chk("bump_allocs", io.allocs, 3);
    chk("bump_full", io.full, 0);

    // LIFO reuse
    do_free(2, e); chk("lifo_free2", e, 0);
    do_free(3, e); chk("lifo_free3", e, 0);
    do_alloc(h, f); chk("lifo_a1", h, 3);
    do_alloc(h, f); chk("lifo_a2", h, 2);
    do_alloc(h, f); chk("lifo_a3", h, 4);
    chk("lifo_inUse", io.inUse, 4);
    chk("lifo_allocs", io.allocs, 4);

    // Exhaustion
    do_reset();
    for (int i = 1; i < N; i++) begin
      do_alloc(h, f);
      chk($sformatf("exh_h%0d", i), h, i);
    end
    chk("exh_full", io.full, 1);
    do_alloc(h, f);
    chk("exh_fail", f, 1);
    chk("exh_fail_h", h, 0);
    chk("exh_inUse", io.inUse, 19);
    do_free(7, e);
    chk("exh_free7", e, 0);
    chk("exh_full_after", io.full, 0);

    // Bad frees
    do_reset();
    do_free(0, e);  chk("bad_free0", e, 1);
    do_free(25, e); chk("bad_free25", e, 1);
    for (int i = 1; i <= 5; i++) do_alloc(h, f);
    chk("bad_alloc5", h, 5);
    do_free(5, e); chk("bad_free5_first", e, 0);
    do_free(5, e); chk("bad_free5_again", e, 1);
    chk("bad_inUse", io.inUse, 4);

    // Collisions: alloc has priority after reset
    do_reset();
    order.delete();
    fork
      do_alloc(h, f);
      do_free(1, e);
    join
    chk("coll1_cnt", order.size(), 2);
    chk("coll1_first", order.size() > 0 ? order[0] : 0, 1);
    chk("coll1_h", h, 1);
    chk("coll1_e", e, 0);
    // A lone alloc hands priority to the free side
    do_alloc(h, f);
    chk("coll_lone_h", h, 1);
    order.delete();
    fork
      do_alloc(h2, f2);
      do_free(1, e);
    join
    chk("coll2_cnt", order.size(), 2);
    chk("coll2_first", order.size() > 0 ? order[0] : 0, 2);
    chk("coll2_e", e, 0);
    chk("coll2_h", h2, 1);

    // Reset while an alloc is held in WAIT
    do_reset();
    do_alloc(h, f);
    io.allocReq = 1'b1;
    begin
      int n = 0;
      while (!io.allocAck && n < 40) begin tick(); n++; end
    end
    tick(); tick();
    chk("rstw_ack_held", io.allocAck, 1);
    chk("rstw_h", io.allocArray, 2);
    reset = 1'b1;
    io.allocReq = 1'b0;
    tick();
    reset = 1'b0;
    chk("rstw_ack_drop", io.allocAck, 0);
    chk("rstw_inUse", io.inUse, 0);
    do_alloc(h, f);
    chk("rstw_realloc", h, 1);
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/array_allocator.md
Name: array_allocator

Overview:
- Sequencer for the heap array-handle resource of the zero machine: grants array numbers to alloc requests and reclaims them on free requests.
- Reuses freed handles LIFO through a freed-arrays stack; otherwise bump-allocates fresh handles.
- Arbitrates between an alloc requester and a free requester that share the handle pool, and maintains in-use and high-water statistics.
- Sits beside the instruction executor; replaces its inline allocs/freedArrays bookkeeping.

Parameters:
- MemoryElementWidth, 12, width of array handles and counters
- NArrays, 20, number of handles; valid handles are 1..NArrays-1, handle 0 is null

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous active-high reset
- allocReq  input  1  alloc request, four-phase handshake
- allocAck  output  1  alloc acknowledge
- allocArray  output  MemoryElementWidth  granted handle, valid while allocAck=1
- allocFail  output  1  alloc rejected (pool exhausted), valid while allocAck=1
- freeReq  input  1  free request, four-phase handshake
- freeArray  input  MemoryElementWidth  handle to free, held stable while freeReq=1
- freeAck  output  1  free acknowledge
- freeError  output  1  free rejected (bad or not-allocated handle), valid while freeAck=1
- inUse  output  MemoryElementWidth  handles currently allocated
- allocs  output  MemoryElementWidth  maximum inUse since reset
- full  output  1  no handle available (stack empty and bump counter = NArrays)

Behaviour:
- Interface: one clock; reset is synchronous and active-high, ports named clock and reset.
- Reset (clock edge with reset=1):
  - all outputs 0; state IDLE.
  - next (bump counter) = 1; stack top = 0; allocated bit vector cleared; priority = alloc.
  - Reset overrides any handshake in flight; a requester that was mid-transaction sees its ack drop and must restart.
- State machine, states IDLE, ACK, WAIT:
  - IDLE: sample requests; if any qualify, perform the operation, register results, go to ACK.
  - ACK: ack (plus result/error) is high this cycle; go to WAIT.
  - WAIT: ack stays high until the served req is seen low, then ack drops next cycle and the state returns to IDLE.
  - Latency: req high at edge n in IDLE gives ack high after edge n; minimum transaction is 3 cycles plus requester drop time.
  - allocArray, allocFail and freeError are held stable for the whole time ack is high.
- Arbitration:
  - Only one operation per transaction.
  - If both reqs are high in IDLE, serve the side named by priority, then toggle priority.
  - A lone request is served immediately and sets priority to the other side.
  - The loser keeps its req high and is served in the next IDLE.
- Alloc:
  - If stack top > 0: pop, allocArray = stack[top-1].
  - Else if next < NArrays: allocArray = next, then next+1.
  - Else: allocFail = 1, allocArray = 0, no state change.
  - On success: set allocated bit, inUse+1, allocs = max(allocs, inUse+1).
- Free:
  - freeError = 1, with no state change, if handle = 0, handle >= next, or its allocated bit is clear (double free).
  - Otherwise: clear the bit, push the handle, inUse-1.
  - The stack cannot overflow because every pushed handle was allocated once.
- full is combinational from registered state: (top = 0) and (next = NArrays). It is updated on the edge following the operation.
- Counter widths: inUse and allocs never exceed NArrays-1; no wrap is possible.

Test Plan:
- Reset, then 3 allocs -> allocArray 1,2,3; inUse=3, allocs=3, full=0, allocFail=0.
- After allocs 1,2,3: free 2, free 3, alloc, alloc -> grants 3 then 2 (LIFO); then alloc -> 4; inUse=4, allocs=4.
- NArrays=20: 19 allocs -> handles 1..19, full=1; 20th alloc -> allocAck with allocFail=1, allocArray=0, inUse=19 unchanged; free 7 -> full=0.
- Free 0, free 25, and free 5 twice (after allocating 5) -> freeError=1 on the three bad frees, freeError=0 on the first free of 5; inUse decremented exactly once.
- allocReq and freeReq raised in the same cycle after reset -> alloc served first; free served in the next transaction; repeat the collision -> free served first.
- Reset asserted while allocAck high in WAIT -> next cycle all outputs 0, inUse=0, next=1; following alloc returns handle 1.
